// File: rtl/shift_register_left_rx.sv
// Serial-to-parallel FP16 receiver.
// Bits arrive LSB first on din/din_valid and are shifted into a 16-bit word.
// A complete word is presented as sign/exponent/fraction together with its
// FP16 class flags, and is held until the downstream side accepts it.
// A frame that stalls for TIMEOUT consecutive idle cycles is dropped.
module shift_register_left_rx #(
  parameter int TIMEOUT = 8  // idle cycles mid-frame before the frame is aborted (1..255)
) (
  input  logic       clk,
  input  logic       res,
  input  logic       din,
  input  logic       din_valid,
  input  logic       out_ready,
  output logic       sign,
  output logic [4:0] exponent,
  output logic [9:0] fraction,
  output logic       out_valid,
  output logic       is_zero,
  output logic       is_subnormal,
  output logic       is_inf,
  output logic       is_nan,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_shift;
  logic [3:0]  r_count;
  logic [7:0]  r_gap;

  logic        w_accept;  // din is taken into the shift register this cycle
  logic        w_done;    // this accepted bit completes the 16-bit word
  logic        w_abort;   // gap timeout expires this cycle
  logic        w_drop;    // a valid bit arrives while the held word is not accepted
  logic [15:0] w_word;    // shift register contents after the current accepted bit
  logic [4:0]  w_exp;
  logic [9:0]  w_frac;

  assign w_word = {din, r_shift[15:1]};
  assign w_exp  = w_word[14:10];
  assign w_frac = w_word[9:0];
  assign busy   = (r_state == S_SHIFT);

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: state-holding elements use non-blocking assignments so every
      // flop samples the pre-edge values regardless of statement order.
      r_state <= w_next;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    w_drop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (din_valid) begin
          w_accept = 1'b1;
          if (r_count == 4'd15) begin
            w_done = 1'b1;
            w_next = S_HOLD;
          end
        end else if (r_gap == GAP_LAST) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (din_valid) begin
            // The accept cycle doubles as bit 0 of the next frame.
            w_accept = 1'b1;
            w_next   = S_SHIFT;
          end else begin
            w_next = S_IDLE;
          end
        end else if (din_valid) begin
          w_drop = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shift register, bit counter and gap counter.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_shift <= '0;
      r_count <= '0;
      r_gap   <= '0;
    end else if (w_accept) begin
      r_shift <= w_word;
      r_count <= r_count + 4'd1;  // wraps 15 -> 0 on the 16th bit
      r_gap   <= '0;
    end else if (w_abort || r_state == S_IDLE) begin
      r_count <= '0;
      r_gap   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_gap <= r_gap + 8'd1;
    end
  end

  // Output word, class flags and status flags.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sign         <= 1'b0;
      exponent     <= '0;
      fraction     <= '0;
      is_zero      <= 1'b0;
      is_subnormal <= 1'b0;
      is_inf       <= 1'b0;
      is_nan       <= 1'b0;
      out_valid    <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (w_done) begin
        sign         <= w_word[15];
        exponent     <= w_exp;
        fraction     <= w_frac;
        is_zero      <= (w_exp == 5'd0)  && (w_frac == 10'd0);
        is_subnormal <= (w_exp == 5'd0)  && (w_frac != 10'd0);
        is_inf       <= (w_exp == 5'd31) && (w_frac == 10'd0);
        is_nan       <= (w_exp == 5'd31) && (w_frac != 10'd0);
      end
      out_valid <= (w_next == S_HOLD);
      frame_err <= w_abort;
      // Sticky: only reset clears a recorded overrun.
      overrun   <= overrun | w_drop;
    end
  end

endmodule

// File: tb/tb_shift_register_left_rx.sv
// Directed bench for shift_register_left_rx.
// Each check compares a packed snapshot of every output against a
// hand-computed expectation: {out_valid, busy, frame_err, overrun,
// is_zero, is_subnormal, is_inf, is_nan, sign, exponent, fraction}.
module tb_shift_register_left_rx;

  logic       clk = 1'b0;
  logic       res;
  logic       din;
  logic       din_valid;
  logic       out_ready;
  logic       sign;
  logic [4:0] exponent;
  logic [9:0] fraction;
  logic       out_valid;
  logic       is_zero;
  logic       is_subnormal;
  logic       is_inf;
  logic       is_nan;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_register_left_rx #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .res          (res),
    .din          (din),
    .din_valid    (din_valid),
    .out_ready    (out_ready),
    .sign         (sign),
    .exponent     (exponent),
    .fraction     (fraction),
    .out_valid    (out_valid),
    .is_zero      (is_zero),
    .is_subnormal (is_subnormal),
    .is_inf       (is_inf),
    .is_nan       (is_nan),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Flag nibble order: {is_zero, is_subnormal, is_inf, is_nan}.
  function automatic logic [23:0] st(input logic ov, input logic bsy,
                                     input logic fe, input logic orun,
                                     input logic [3:0] fl, input logic [15:0] w);
    return {ov, bsy, fe, orun, fl, w};
  endfunction

  task automatic check(input string tag, input logic [23:0] exp_st);
    logic [23:0] got;
    got = {out_valid, busy, frame_err, overrun,
           is_zero, is_subnormal, is_inf, is_nan,
           sign, exponent, fraction};
    n_checks++;
    assert (got === exp_st) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp_st);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send bits lo..hi of w, one per cycle, LSB first.
  task automatic send_range(input logic [15:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      din       = w[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  // Accept the held word without starting a new frame.
  task automatic release_word();
    out_ready = 1'b1;
    din_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    res       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    out_ready = 1'b0;

    // Reset is asynchronous: outputs are zero before any clock edge.
    #3;
    check("reset_async", st(0, 0, 0, 0, 4'b0000, 16'h0000));
    tick();
    tick();
    res = 1'b0;
    check("reset_released", st(0, 0, 0, 0, 4'b0000, 16'h0000));

    // 1.0: sign 0, exponent 0x0F, fraction 0, no class flag.
    send_range(16'h3C00, 0, 14);
    check("one_mid_frame", st(0, 1, 0, 0, 4'b0000, 16'h0000));
    send_range(16'h3C00, 15, 15);
    check("one_held", st(1, 0, 0, 0, 4'b0000, 16'h3C00));
    release_word();
    check("one_released", st(0, 0, 0, 0, 4'b0000, 16'h3C00));

    // Class coverage: +inf, NaN with sign set, smallest subnormal.
    send_range(16'h7C00, 0, 15);
    check("inf_held", st(1, 0, 0, 0, 4'b0010, 16'h7C00));
    release_word();
    send_range(16'hFE01, 0, 15);
    check("nan_held", st(1, 0, 0, 0, 4'b0001, 16'hFE01));
    release_word();
    send_range(16'h0001, 0, 15);
    check("subnormal_held", st(1, 0, 0, 0, 4'b0100, 16'h0001));
    release_word();
    check("subnormal_released", st(0, 0, 0, 0, 4'b0100, 16'h0001));

    // Gap timeout: 7 bits then 8 idle cycles aborts the frame.
    send_range(16'h0055, 0, 6);
    check("gap_partial", st(0, 1, 0, 0, 4'b0100, 16'h0001));
    repeat (7) tick();
    check("gap_7_idle", st(0, 1, 0, 0, 4'b0100, 16'h0001));
    out_ready = 1'b1;  // ignored outside HOLD
    tick();
    out_ready = 1'b0;
    check("gap_abort", st(0, 0, 1, 0, 4'b0100, 16'h0001));
    tick();
    check("gap_err_pulse_end", st(0, 0, 0, 0, 4'b0100, 16'h0001));
    send_range(16'h0000, 0, 15);
    check("zero_held", st(1, 0, 0, 0, 4'b1000, 16'h0000));
    release_word();

    // Overrun: 3 bits arrive while the word is held and not accepted.
    send_range(16'h4248, 0, 15);
    check("ovr_held", st(1, 0, 0, 0, 4'b0000, 16'h4248));
    send_range(16'hFFFF, 0, 2);
    check("ovr_dropped", st(1, 0, 0, 1, 4'b0000, 16'h4248));
    release_word();
    check("ovr_sticky", st(0, 0, 0, 1, 4'b0000, 16'h4248));

    // Accept coincident with bit 0 of the next frame.
    send_range(16'h3555, 0, 15);
    check("b2b_first_held", st(1, 0, 0, 1, 4'b0000, 16'h3555));
    din       = 1'b1;  // bit 0 of 0xABCD
    din_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    din_valid = 1'b0;
    check("b2b_handover", st(0, 1, 0, 1, 4'b0000, 16'h3555));
    send_range(16'hABCD, 1, 15);
    check("b2b_second_held", st(1, 0, 0, 1, 4'b0000, 16'hABCD));
    release_word();

    // Reset mid-frame after 10 bits, then a clean frame.
    send_range(16'hFFFF, 0, 9);
    check("rst_partial", st(0, 1, 0, 1, 4'b0000, 16'hABCD));
    #2;
    res = 1'b1;
    #1;
    check("rst_mid_frame", st(0, 0, 0, 0, 4'b0000, 16'h0000));
    res = 1'b0;
    send_range(16'h1234, 0, 15);
    check("rst_then_frame", st(1, 0, 0, 0, 4'b0000, 16'h1234));
    release_word();
    check("rst_frame_released", st(0, 0, 0, 0, 4'b0000, 16'h1234));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_register_left_rx.md
SHIFT_REGISTER_LEFT_RX -- requirements
Module: shift_register_left_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, meaning the number of consecutive idle cycles mid-frame that aborts the frame (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port res, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port din, input, 1, the serial data bit, LSB first.
REQ-005 SHALL have port din_valid, input, 1, which qualifies din in the same cycle.
REQ-006 SHALL have port out_ready, input, 1, downstream accept.
REQ-007 SHALL have port sign, output, 1, the assembled bit 15.
REQ-008 SHALL have port exponent, output, 5, the assembled bits 14:10.
REQ-009 SHALL have port fraction, output, 10, the assembled bits 9:0.
REQ-010 SHALL have port out_valid, output, 1, meaning the word is held and valid.
REQ-011 SHALL have ports is_zero, is_subnormal, is_inf and is_nan: output, 1 bit each, FP16 class of the held word.
REQ-012 SHALL have port frame_err, output, 1, a one-cycle pulse on a timeout abort.
REQ-013 SHALL have port overrun, output, 1, a sticky flag for a dropped input bit.
REQ-014 SHALL have port busy, output, 1, high while a frame is partially received.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, SHIFT and HOLD.
REQ-016 SHALL, on every accepted bit, shift the 16-bit register right with din entering at bit 15, so that the first bit received ends at bit 0.
REQ-017 SHALL use a 4-bit bit counter: cleared in IDLE, incremented per accepted bit, wrapping 15->0 on the 16th bit.
REQ-018 SHALL, in IDLE, on din_valid=1: accept bit 0, set count=1 and move to SHIFT.
REQ-019 SHALL, in SHIFT, on din_valid=1: accept the bit; the 16th accepted bit moves the FSM to HOLD.
REQ-020 SHALL, in SHIFT, count consecutive din_valid=0 cycles in a gap counter that is cleared on each accepted bit.
REQ-021 SHALL, when the gap counter reaches TIMEOUT: discard the partial frame, pulse frame_err for one cycle, return to IDLE and clear the counters.
REQ-022 SHALL register sign, exponent, fraction and the class flags on the cycle of the 16th bit; out_valid is high the following cycle, giving one cycle of latency after the last bit.
REQ-023 SHALL classify the held word as follows:
- is_zero: exponent=0 and fraction=0.
- is_subnormal: exponent=0 and fraction!=0.
- is_inf: exponent=31 and fraction=0.
- is_nan: exponent=31 and fraction!=0.
- At most one class flag is high at a time.
REQ-024 SHALL hold out_valid and all data/flag outputs stable in HOLD until out_ready=1.
REQ-025 SHALL, in HOLD with out_ready=1 and din_valid=0, deassert out_valid the next cycle and go to IDLE.
REQ-026 SHALL, in HOLD with out_ready=1 and din_valid=1 in the same cycle, accept that bit as bit 0 of the next frame and go to SHIFT with count=1.
REQ-027 SHALL, in HOLD with out_ready=0 and din_valid=1, drop the bit, set overrun and leave the held word unchanged.
REQ-028 SHALL clear overrun only by reset.
REQ-029 SHALL drive busy=1 exactly in SHIFT.
REQ-030 SHALL not apply the gap timeout in IDLE or HOLD.
REQ-031 SHALL ignore out_ready outside HOLD.
REQ-032 SHALL ignore din whenever din_valid=0.

Reset
REQ-033 SHALL, while res=1, immediately force the following, regardless of the clock:
- FSM to IDLE.
- Shift register, bit counter and gap counter to 0.
- sign=0, exponent=0, fraction=0.
- out_valid=0, frame_err=0, overrun=0, busy=0.
- is_zero=0, is_subnormal=0, is_inf=0, is_nan=0.
REQ-034 SHALL discard any partial or held frame on reset mid-operation; the first din_valid after res falls is bit 0 of a new frame.

Verification
REQ-035 SHALL cover: 0x3C00 sent LSB-first on 16 consecutive din_valid cycles -> out_valid 1 cycle later with sign=0, exponent=0x0F, fraction=0x000 and all class flags 0.
REQ-036 SHALL cover: 0x7C00, then 0xFE01, then 0x0001, each accepted with out_ready=1 -> is_inf; then is_nan with sign=1; then is_subnormal with fraction=0x001.
REQ-037 SHALL cover: 7 bits, then a din_valid=0 gap of 8 cycles (TIMEOUT=8) -> frame_err pulses once, busy=0, and the next 16 bits (0x0000) produce is_zero.
REQ-038 SHALL cover: word held with out_ready=0 while 3 more din_valid bits arrive -> overrun=1, outputs unchanged, overrun still 1 after a later accept.
REQ-039 SHALL cover: out_ready=1 coincident with the first bit of the next frame -> no bit lost; the second word (0xABCD) is reassembled exactly.
REQ-040 SHALL cover: res pulsed after bit 10 -> all outputs 0 asynchronously, and a subsequent full 0x1234 frame is received correctly.
